mem_responder: RTL

Memory-side responder for the processor's Valid/RW/ready memory handshake. It sits between the control unit's address/data buses and a word-addressed single-port RAM, and serves both instruction fetches and load/store accesses. The handshake works like this: the initiator raises `valid`, the responder drops `ready` while it works, raises `ready` again with read data, then waits for the initiator to release `valid`.

---
 rtl/mem_responder_pkg.sv | 13 +
 rtl/mem_responder_if.sv | 24 ++
 rtl/mem_responder_mem_array.sv | 22 ++
 rtl/mem_responder.sv | 120 ++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared package `common`: data width and responder FSM state type.
// Used by mem_responder, mem_array and the responder bus interface.
package common;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } memRespStates;

endpackage

// File: rtl/mem_responder_if.sv
// Valid/RW/ready memory bus between an initiator (master) and mem_responder (slave).
// Optional err signal exists only when MEMRESP_RANGE_CHECK_EN is defined.
interface mem_responder_if;
  import common::*;

  // Handshake: master raises valid with rw/addr/wdata; slave drops ready while
  // working, raises ready with rdata (reads) when done, then waits for valid=0.
  logic              valid;
  logic              rw;
  logic [31:0]       addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;
`ifdef MEMRESP_RANGE_CHECK_EN
  logic              err;

  modport master (output valid, rw, addr, wdata, input rdata, ready, err);
  modport slave  (input valid, rw, addr, wdata, output rdata, ready, err);
`else
  modport master (output valid, rw, addr, wdata, input rdata, ready);
  modport slave  (input valid, rw, addr, wdata, output rdata, ready);
`endif

endinterface

// File: rtl/mem_responder_mem_array.sv
// mem_array: synchronous single-port RAM, 2^AW x DATA_W, registered read-first
// output, no reset.
module mem_array
  import common::*;
#(
  parameter int AW = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     idx,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= din;
    dout <= mem[idx];
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: IDLE/BUSY/DONE responder in front of mem_array.
// Optional range checking and err output with MEMRESP_RANGE_CHECK_EN.
module mem_responder
  import common::*;
#(
  parameter int AW          = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic          clk,
  input  logic          reset,
  mem_responder_if.slave bus,
  output memRespStates  state_o
);

  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  memRespStates      state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              rw_q, rw_d;
  logic [31:0]       addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;

  logic              oor;
  logic              mem_we;
  logic [AW-1:0]     mem_idx;
  logic [DATA_W-1:0] mem_dout;

`ifdef MEMRESP_RANGE_CHECK_EN
  assign oor     = |addr_q[31:AW];
  assign bus.err = err_q;
`else
  logic addr_hi_unused;
  assign addr_hi_unused = |{addr_q[31:AW], err_q};
  assign oor            = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ready_d = ready_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.valid) begin
          rw_d    = bus.rw;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          cnt_d   = CW'(WAIT_CYCLES);
          ready_d = 1'b0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          if (rw_q) rdata_d = oor ? '0 : mem_dout;
          err_d   = oor;
          ready_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        // A held valid is the same request; only valid=0 re-arms IDLE.
        if (!bus.valid) begin
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // In IDLE the RAM already reads the incoming address, so with zero wait
  // cycles the word is on mem_dout by the access edge.
  assign mem_idx = (state_q == IDLE) ? bus.addr[AW-1:0] : addr_q[AW-1:0];
  assign mem_we  = (state_q == BUSY) && (cnt_q == '0) && !rw_q && !oor;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  mem_array #(.AW(AW)) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .idx  (mem_idx),
    .din  (wdata_q),
    .dout (mem_dout)
  );

  assign bus.rdata = rdata_q;
  assign bus.ready = ready_q;
  assign state_o   = state_q;

endmodule
